// File: rtl/button_matrix_decoder_pkg.sv
// Shared types and helpers for the key-matrix decoder (button_matrix_decoder).
package bmd_pkg;

  typedef enum logic [1:0] {
    SAMPLE_ZERO,
    SAMPLE_LEGAL,
    SAMPLE_MULTI
  } sample_class_t;

  function automatic int code_w(input int rows, input int cols);
    return (rows * cols <= 2) ? 1 : $clog2(rows * cols);
  endfunction

endpackage

// File: rtl/button_matrix_decoder_onehot_encoder.sv
// Classifies a sense vector as zero / one-hot / multi-hot and encodes its set-bit index.
module onehot_encoder #(
  parameter int W = 4
) (
  input  logic [W-1:0]         in,
  output logic [$clog2(W)-1:0] idx,
  output logic                 is_zero,
  output logic                 is_onehot,
  output logic                 is_multi
);

  localparam int IW = $clog2(W);

  // OR-encoding is only meaningful for one-hot inputs; callers gate on is_onehot.
  always_comb begin
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (in[i]) idx = idx | IW'(i);
    end
  end

  assign is_zero   = (in == '0);
  assign is_onehot = !is_zero && ((in & (in - W'(1))) == '0);
  assign is_multi  = !is_zero && !is_onehot;

endmodule

// File: rtl/button_matrix_decoder.sv
// Key-matrix sample to linear key code, registered with 1-clk latency.
// Optional debounce filter enabled by defining BMD_DEBOUNCE_EN.
module button_matrix_decoder
  import bmd_pkg::*;
#(
  parameter int RWIDTH          = 4,
  parameter int CWIDTH          = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [RWIDTH-1:0]                     row,
  input  logic [CWIDTH-1:0]                     col,
  output logic [code_w(RWIDTH, CWIDTH)-1:0]     data_out,
  output logic                                  valid,
  output logic                                  err
);

  localparam int OW  = code_w(RWIDTH, CWIDTH);
  localparam int RIW = $clog2(RWIDTH);
  localparam int CIW = $clog2(CWIDTH);

  logic [RIW-1:0] ridx;
  logic [CIW-1:0] cidx;
  logic           r_zero, r_onehot, r_multi;
  logic           c_zero, c_onehot, c_multi;

  onehot_encoder #(.W(RWIDTH)) u_row_enc (
    .in        (row),
    .idx       (ridx),
    .is_zero   (r_zero),
    .is_onehot (r_onehot),
    .is_multi  (r_multi)
  );

  onehot_encoder #(.W(CWIDTH)) u_col_enc (
    .in        (col),
    .idx       (cidx),
    .is_zero   (c_zero),
    .is_onehot (c_onehot),
    .is_multi  (c_multi)
  );

  sample_class_t  cls;
  logic [OW-1:0]  dec_code;
  logic           dec_valid;
  logic           dec_err;

  // Multi-hot wins over zero; legal only when both vectors are one-hot.
  always_comb begin
    cls = SAMPLE_ZERO;
    if (r_multi || c_multi)         cls = SAMPLE_MULTI;
    else if (r_zero || c_zero)      cls = SAMPLE_ZERO;
    else if (r_onehot && c_onehot)  cls = SAMPLE_LEGAL;
  end

  always_comb begin
    dec_code  = '0;
    dec_valid = 1'b0;
    dec_err   = 1'b0;
    case (cls)
      SAMPLE_LEGAL: begin
        dec_code  = OW'(ridx) * OW'(CWIDTH) + OW'(cidx);
        dec_valid = 1'b1;
      end
      SAMPLE_MULTI: dec_err = 1'b1;
      default: ;
    endcase
  end

  logic [OW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

`ifdef BMD_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [OW+1:0]    dec_cand;
  logic [OW+1:0]    cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign dec_cand = {dec_valid, dec_code, dec_err};

  // Counter starts at 1 on a new candidate and saturates at DEBOUNCE_CYCLES.
  always_comb begin
    cand_d  = dec_cand;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (dec_cand != cand_q)  cnt_d = CNT_W'(1);
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    if (cnt_d == CNT_MAX) begin
      data_d  = dec_code;
      valid_d = dec_valid;
      err_d   = dec_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  always_comb begin
    data_d  = dec_code;
    valid_d = dec_valid;
    err_d   = dec_err;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_button_matrix_decoder.sv
// Directed self-checking bench for button_matrix_decoder (4x4 matrix).
module tb_button_matrix_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] data_out;
  logic       valid;
  logic       err;

  int tests = 0;
  int fails = 0;

  button_matrix_decoder #(
    .RWIDTH          (4),
    .CWIDTH          (4),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .data_out (data_out),
    .valid    (valid),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Apply a sample in the low phase, then look 1 time unit after the next rising edge.
  task automatic step(input logic [3:0] r, input logic [3:0] c);
    @(negedge clk);
    row = r;
    col = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input int d, input int v, input int e);
    chk({tag, ".data"},  32'(data_out), 32'(d));
    chk({tag, ".valid"}, 32'(valid),    32'(v));
    chk({tag, ".err"},   32'(err),      32'(e));
  endtask

  initial begin
    rst = 1'b1;
    row = 4'b0000;
    col = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

`ifdef BMD_DEBOUNCE_EN
    // Key 9 = row 2, col 1
    for (int k = 0; k < 3; k++) step(4'b0100, 4'b0010);
    chk_out("db_short3", 0, 0, 0);
    step(4'b0001, 4'b1000);
    chk_out("db_changed", 0, 0, 0);
    for (int k = 0; k < 3; k++) step(4'b0100, 4'b0010);
    chk_out("db_held3", 0, 0, 0);
    step(4'b0100, 4'b0010);
    chk_out("db_held4", 9, 1, 0);
    step(4'b0100, 4'b0010);
    chk_out("db_held5", 9, 1, 0);
`else
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        step(4'(1 << i), 4'(1 << j));
        chk_out($sformatf("sweep_r%0d_c%0d", i, j), 4 * i + j, 1, 0);
      end
    end

    step(4'b0100, 4'b1000);
    chk_out("key11", 11, 1, 0);
    step(4'b0001, 4'b0001);
    chk_out("key0_legal", 0, 1, 0);
    step(4'b0000, 4'b0001);
    chk_out("row_zero", 0, 0, 0);
    step(4'b0010, 4'b0000);
    chk_out("col_zero", 0, 0, 0);
    step(4'b0110, 4'b0001);
    chk_out("row_multi", 0, 0, 1);
    step(4'b0001, 4'b0011);
    chk_out("col_multi", 0, 0, 1);
    step(4'b1100, 4'b0000);
    chk_out("multi_over_zero", 0, 0, 1);
    step(4'b1000, 4'b1000);
    chk_out("key15", 15, 1, 0);

    // Mid-stream asynchronous reset while key 5 is held
    step(4'b0010, 4'b0010);
    chk_out("key5_held", 5, 1, 0);
    rst = 1'b1;
    #1;
    chk_out("async_reset", 0, 0, 0);
    #1;
    rst = 1'b0;
    #1;
    chk_out("post_release_no_edge", 0, 0, 0);
    @(posedge clk);
    #1;
    chk_out("key5_after_reset", 5, 1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
